dcache_req_ctrl: RTL and testbench

Memory-stage request controller that drives the datapath side of the data-cache interface. It accepts one load/store per pipeline slot and splits the address into tag, index and offset. It holds the pipeline stalled until the cache answers with a hit, and returns read data. On CPU halt it issues the cache halt and waits for the flush to complete before reporting the processor halted.

---
 rtl/dcache_req_ctrl_pkg.sv | 16 +
 rtl/sat_counter.sv | 30 +++
 rtl/dcache_req_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dcache_req_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_req_ctrl_pkg.sv
// Shared CPU types for the memory-stage data-cache request path.
// Holds the request FSM encoding and cache address field widths.
package dcache_req_ctrl_pkg;

  localparam int DTAG_W = 26;
  localparam int DIDX_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_FLUSH,
    S_HALTED
  } dreq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clear_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (inc_i && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dcache_req_ctrl.sv
// Memory-stage data-cache request controller: issues one load/store,
// stalls until dhit, then handles halt/flush handshake.
module dcache_req_ctrl
  import dcache_req_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              mem_valid,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic              mem_atomic,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              halt_in,
  output logic [DTAG_W-1:0] tag,
  output logic [DIDX_W-1:0] indx,
  output logic              offset,
  output logic              dREN,
  output logic              dWEN,
  output logic              datomic,
  output logic              halt,
  output logic [31:0]       dstore,
  input  logic              dhit,
  input  logic              flushed,
  input  logic [31:0]       memout,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              halted,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int WT_W = $clog2(TIMEOUT + 1);
  localparam logic [WT_W-1:0] WT_MAX  = WT_W'(TIMEOUT);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(TIMEOUT - 1);

  dreq_state_t     state_q;
  logic [29:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic [WT_W-1:0] wait_q;
  logic            load_q;
  logic            dren_q;
  logic            dwen_q;
  logic            datomic_q;
  logic            halt_q;
  logic            halted_q;
  logic            terr_q;
  logic            hpend_q;

  logic accept;
  logic in_access;
  logic first;
  logic unused_addr;

  assign unused_addr = ^mem_addr[1:0];

  assign accept    = (state_q == S_IDLE) && mem_valid
                   && (mem_ren || mem_wen);
  assign in_access = (state_q == S_ACCESS);
  assign first     = (wait_q == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wait_q    <= '0;
      load_q    <= 1'b0;
      dren_q    <= 1'b0;
      dwen_q    <= 1'b0;
      datomic_q <= 1'b0;
      halt_q    <= 1'b0;
      halted_q  <= 1'b0;
      terr_q    <= 1'b0;
      hpend_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q    <= mem_addr[31:2];
            wdata_q   <= mem_wdata;
            load_q    <= mem_ren & ~mem_wen;
            dren_q    <= mem_ren & ~mem_wen;
            dwen_q    <= mem_wen;
            datomic_q <= mem_atomic;
            hpend_q   <= halt_in;
            wait_q    <= '0;
            state_q   <= S_ACCESS;
          end else if (halt_in) begin
            halt_q  <= 1'b1;
            state_q <= S_FLUSH;
          end
        end
        S_ACCESS: begin
          if (dhit) begin
            if (load_q) rdata_q <= memout;
            dren_q    <= 1'b0;
            dwen_q    <= 1'b0;
            datomic_q <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            // saturate so a very long miss cannot wrap and look like a hit
            if (wait_q != WT_MAX) wait_q <= wait_q + 1'b1;
            if (wait_q == WT_LAST) terr_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (hpend_q) begin
            hpend_q <= 1'b0;
            halt_q  <= 1'b1;
            state_q <= S_FLUSH;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (flushed) begin
            halted_q <= 1'b1;
            state_q  <= S_HALTED;
          end
        end
        S_HALTED: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk_i   (CLK),
    .rst_i   (RST),
    .inc_i   (in_access & dhit & first),
    .clear_i (1'b0),
    .cnt_o   (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk_i   (CLK),
    .rst_i   (RST),
    .inc_i   (in_access & dhit & ~first),
    .clear_i (1'b0),
    .cnt_o   (miss_cnt)
  );

  assign tag         = addr_q[29:4];
  assign indx        = addr_q[3:1];
  assign offset      = addr_q[0];
  assign dstore      = wdata_q;
  assign dREN        = dren_q;
  assign dWEN        = dwen_q;
  assign datomic     = datomic_q;
  assign halt        = halt_q;
  assign halted      = halted_q;
  assign timeout_err = terr_q;
  assign rdata       = rdata_q;
  assign rdata_valid = (state_q == S_DONE) && load_q;
  assign stall       = accept || in_access
                    || (state_q == S_FLUSH)
                    || (state_q == S_HALTED);

endmodule

// File: tb/tb_dcache_req_ctrl.sv
// Directed plus randomized bench for dcache_req_ctrl against a
// transaction-level model of latency, counters and timeout.
module tb_dcache_req_ctrl;

  localparam int TO   = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          mem_valid, mem_ren, mem_wen, mem_atomic;
  logic [31:0]   mem_addr, mem_wdata;
  logic          halt_in;
  logic [25:0]   tag;
  logic [2:0]    indx;
  logic          offset;
  logic          dREN, dWEN, datomic, halt;
  logic [31:0]   dstore;
  logic          dhit, flushed;
  logic [31:0]   memout;
  logic          stall;
  logic [31:0]   rdata;
  logic          rdata_valid, halted, timeout_err;
  logic [CW-1:0] hit_cnt, miss_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  int          exp_hit, exp_miss;
  logic        exp_terr;
  logic [31:0] exp_rdata;

  dcache_req_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .mem_valid   (mem_valid),
    .mem_ren     (mem_ren),
    .mem_wen     (mem_wen),
    .mem_atomic  (mem_atomic),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .halt_in     (halt_in),
    .tag         (tag),
    .indx        (indx),
    .offset      (offset),
    .dREN        (dREN),
    .dWEN        (dWEN),
    .datomic     (datomic),
    .halt        (halt),
    .dstore      (dstore),
    .dhit        (dhit),
    .flushed     (flushed),
    .memout      (memout),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .halted      (halted),
    .timeout_err (timeout_err),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tg, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tg, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_hit   = 0;
    exp_miss  = 0;
    exp_terr  = 1'b0;
    exp_rdata = '0;
  endtask

  task automatic idle_inputs();
    mem_valid  = 1'b0;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    mem_atomic = 1'b0;
    halt_in    = 1'b0;
  endtask

  // Called at a falling edge with the controller idle.
  task automatic do_op(input logic ren, input logic wen,
                       input logic atom, input logic [31:0] addr,
                       input logic [31:0] wd, input int dly,
                       input logic [31:0] mo, input logic hin);
    logic is_ld;
    logic act;
    int   stalls;
    int   wcyc;
    is_ld  = ren & ~wen;
    act    = ren | wen;
    stalls = 0;
    wcyc   = 0;
    mem_valid  = 1'b1;
    mem_ren    = ren;
    mem_wen    = wen;
    mem_atomic = atom;
    mem_addr   = addr;
    mem_wdata  = wd;
    halt_in    = hin;
    #1;
    chk("accept_stall", stall, act);
    if (stall) stalls++;
    @(negedge CLK);
    idle_inputs();
    mem_addr  = $urandom;
    mem_wdata = $urandom;
    if (!act) begin
      chk("ignored_stall", stall, 0);
      chk("ignored_dren", dREN, 0);
      chk("ignored_dwen", dWEN, 0);
      return;
    end
    for (int k = 0; k <= dly; k++) begin
      if (k >= TO) exp_terr = 1'b1;
      chk("acc_dren", dREN, is_ld);
      chk("acc_dwen", dWEN, wen);
      chk("acc_datomic", datomic, atom);
      chk("acc_dstore", dstore, wd);
      chk("acc_tag", 32'(tag), 32'(addr[31:6]));
      chk("acc_indx", 32'(indx), 32'(addr[5:3]));
      chk("acc_offset", offset, addr[2]);
      chk("acc_halt", halt, 0);
      chk("acc_rdata_hold", rdata, exp_rdata);
      chk("acc_terr", timeout_err, exp_terr);
      if (dWEN) wcyc++;
      if (stall) stalls++;
      dhit   = (k == dly);
      memout = (k == dly) ? mo : $urandom;
      @(negedge CLK);
    end
    dhit   = 1'b0;
    memout = $urandom;
    if (dly == 0) begin
      if (exp_hit < CMAX) exp_hit++;
    end else begin
      if (exp_miss < CMAX) exp_miss++;
    end
    if (is_ld) exp_rdata = mo;
    chk("done_stall", stall, 0);
    chk("done_rvalid", rdata_valid, is_ld);
    chk("done_rdata", rdata, exp_rdata);
    chk("done_dren", dREN, 0);
    chk("done_dwen", dWEN, 0);
    chk("done_hit_cnt", 32'(hit_cnt), 32'(exp_hit));
    chk("done_miss_cnt", 32'(miss_cnt), 32'(exp_miss));
    chk("done_terr", timeout_err, exp_terr);
    chk("stall_cycles", stalls, dly + 2);
    chk("dwen_cycles", wcyc, wen ? dly + 1 : 0);
    @(negedge CLK);
    if (!hin) begin
      chk("idle_stall", stall, 0);
      chk("idle_rvalid", rdata_valid, 0);
    end
  endtask

  initial begin
    RST     = 1'b1;
    dhit    = 1'b0;
    flushed = 1'b0;
    memout  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    idle_inputs();
    model_reset();
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_dren", dREN, 0);
    chk("rst_dwen", dWEN, 0);
    chk("rst_halt", halt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_tag", 32'(tag), 0);
    chk("rst_hit", 32'(hit_cnt), 0);
    chk("rst_miss", 32'(miss_cnt), 0);
    @(negedge CLK);
    RST = 1'b0;

    // load hit
    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0048, 32'h0,
          0, 32'hDEAD_BEEF, 1'b0);
    chk("lh_hit_cnt", 32'(hit_cnt), 1);
    chk("lh_rdata", rdata, 32'hDEAD_BEEF);

    // store miss, 5 ACCESS cycles
    do_op(1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h1234_5678,
          4, 32'h5555_AAAA, 1'b0);
    chk("sm_miss_cnt", 32'(miss_cnt), 1);
    chk("sm_rdata", rdata, 32'hDEAD_BEEF);

    // both ren and wen: store; neither: ignored
    do_op(1'b1, 1'b1, 1'b1, 32'h0000_0A0C, 32'h0BAD_F00D,
          1, 32'h7777_7777, 1'b0);
    do_op(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0,
          0, 32'h0, 1'b0);

    // timeout
    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0,
          12, 32'hCAFE_0001, 1'b0);
    chk("to_sticky", timeout_err, 1);

    // saturation
    for (int i = 0; i < 5; i++)
      do_op(1'b1, 1'b0, 1'b0, $urandom, 32'h0, 0, $urandom, 1'b0);
    chk("sat_hit_cnt", 32'(hit_cnt), CMAX);

    for (int i = 0; i < 24; i++)
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom, $urandom,
            $urandom_range(0, 9), $urandom, 1'b0);

    // reset mid-ACCESS
    mem_valid = 1'b1;
    mem_ren   = 1'b1;
    mem_addr  = 32'h0000_1230;
    @(negedge CLK);
    idle_inputs();
    chk("ra_dren1", dREN, 1);
    @(negedge CLK);
    chk("ra_dren2", dREN, 1);
    #2 RST = 1'b1;
    #1;
    model_reset();
    chk("ra_dren", dREN, 0);
    chk("ra_stall", stall, 0);
    chk("ra_hit", 32'(hit_cnt), 0);
    chk("ra_miss", 32'(miss_cnt), 0);
    chk("ra_terr", timeout_err, 0);
    chk("ra_rdata", rdata, 0);
    @(negedge CLK);
    RST = 1'b0;
    do_op(1'b1, 1'b0, 1'b0, 32'h0000_00F8, 32'h0,
          0, 32'h0123_4567, 1'b0);
    chk("ra_next_hit", 32'(hit_cnt), 1);

    // halt with a pending op
    do_op(1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'hA5A5_5A5A,
          1, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("fl_halt", halt, 1);
      chk("fl_dren", dREN, 0);
      chk("fl_dwen", dWEN, 0);
      chk("fl_stall", stall, 1);
      chk("fl_halted", halted, 0);
      flushed = (k == 2);
      @(negedge CLK);
    end
    flushed   = 1'b0;
    mem_valid = 1'b1;
    mem_ren   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("hd_halted", halted, 1);
      chk("hd_halt", halt, 1);
      chk("hd_stall", stall, 1);
      chk("hd_dren", dREN, 0);
      @(negedge CLK);
    end
    idle_inputs();
    #2 RST = 1'b1;
    #1;
    chk("hr_halted", halted, 0);
    chk("hr_halt", halt, 0);
    @(negedge CLK);
    RST = 1'b0;

    // halt from idle, then reset mid-FLUSH
    halt_in = 1'b1;
    #1;
    chk("hi_stall", stall, 0);
    @(negedge CLK);
    halt_in = 1'b0;
    chk("hi_halt", halt, 1);
    chk("hi_stall_fl", stall, 1);
    chk("hi_dren", dREN, 0);
    #2 RST = 1'b1;
    #1;
    chk("fr_halt", halt, 0);
    chk("fr_stall", stall, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
